// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encoding and FSM states.
package ex_muldiv_pkg;

  localparam int unsigned OpW = 3;

  typedef enum logic [OpW-1:0] {
    OpNop   = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  function automatic logic is_mul_op(input op_e op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage request/result bundle between the pipeline (master) and ex_muldiv (slave).
interface ex_muldiv_if #(
  parameter int unsigned DATA_W = 32
);
  logic                          valid_i;
  logic [ex_muldiv_pkg::OpW-1:0] op_i;
  logic [DATA_W-1:0]             src1_i;
  logic [DATA_W-1:0]             src2_i;
  logic                          flush_i;
  logic                          stallreq_o;
  logic                          busy_o;
  logic                          done_o;
  logic [DATA_W-1:0]             hi_o;
  logic [DATA_W-1:0]             lo_o;

  modport master (
    output valid_i, op_i, src1_i, src2_i, flush_i,
    input  stallreq_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  valid_i, op_i, src1_i, src2_i, flush_i,
    output stallreq_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per step.
module ex_muldiv_div_iter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   trial;

  // The dividend shifts out of the quotient register MSB-first as quotient bits shift in.
  assign rem_shift = {rem_q, quo_q[DATA_W-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  // High during the step that produces the final quotient bit.
  assign done      = step && (cnt_q == CntW'(DATA_W - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      if (!trial[DATA_W]) begin
        rem_q <= trial[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[DATA_W-1:0];
        quo_q <= {quo_q[DATA_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/DIV/MTHI/MTLO unit owning HI/LO; stalls the pipeline while busy.
// Optional MULDIV_DIV_EARLY_OUT_EN: trivial divides (zero divisor, |a|<|b|) skip iteration.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(MUL_STAGES) + 1;
  localparam int unsigned ProdW = 2 * DATA_W;

  state_e            state_q;
  op_e               op_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              early_q;

  op_e               op;
  logic              is_idle;
  logic              accept;
  logic              mt_write;
  logic              div_skip;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;
  logic              div_done;
  logic              div_step;
  logic [DATA_W-1:0] hi_res;
  logic [DATA_W-1:0] lo_res;
  logic [ProdW-1:0]  mul_a;
  logic [ProdW-1:0]  mul_b;
  logic [ProdW-1:0]  mul_pipe_q [MUL_STAGES];

  assign op       = op_e'(bus.op_i);
  assign is_idle  = (state_q == StIdle);
  assign accept   = is_idle && !rst && bus.valid_i && !bus.flush_i &&
                    (is_mul_op(op) || is_div_op(op));
  assign mt_write = is_idle && bus.valid_i && !bus.flush_i &&
                    ((op == OpMthi) || (op == OpMtlo));

  assign bus.stallreq_o = accept ||
                          (((state_q == StMul) || (state_q == StDiv)) && !bus.flush_i);
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

  // Magnitudes come straight from the forwarded operands so the divider loads on accept.
  assign a_mag = ((op == OpDiv) && bus.src1_i[DATA_W-1]) ? -bus.src1_i : bus.src1_i;
  assign b_mag = ((op == OpDiv) && bus.src2_i[DATA_W-1]) ? -bus.src2_i : bus.src2_i;

`ifdef MULDIV_DIV_EARLY_OUT_EN
  assign div_skip = (bus.src2_i == '0) || (a_mag < b_mag);
`else
  assign div_skip = 1'b0;
`endif

  assign div_step = (state_q == StDiv) && !bus.flush_i;

  ex_muldiv_div_iter #(
    .DATA_W (DATA_W)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div_op(op)),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign mul_a = {{DATA_W{(op_q == OpMult) & src1_q[DATA_W-1]}}, src1_q};
  assign mul_b = {{DATA_W{(op_q == OpMult) & src2_q[DATA_W-1]}}, src2_q};

  // Stage 0 is the product register; the last stage is valid in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        mul_pipe_q[i] <= '0;
      end
    end else if (state_q == StMul) begin
      mul_pipe_q[0] <= mul_a * mul_b;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
    end
  end

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    if (is_mul_op(op_q)) begin
      {hi_res, lo_res} = mul_pipe_q[MUL_STAGES-1];
    end else if (src2_q == '0) begin
      lo_res = '1;
      hi_res = src1_q;
    end else if (early_q) begin
      lo_res = '0;
      hi_res = src1_q;
    end else begin
      lo_res = ((op_q == OpDiv) && (src1_q[DATA_W-1] ^ src2_q[DATA_W-1])) ? -div_quo : div_quo;
      hi_res = ((op_q == OpDiv) && src1_q[DATA_W-1]) ? -div_rem : div_rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      src1_q  <= '0;
      src2_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      early_q <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= op;
            src1_q  <= bus.src1_i;
            src2_q  <= bus.src2_i;
            busy_q  <= 1'b1;
            early_q <= 1'b0;
            if (is_mul_op(op)) begin
              state_q <= StMul;
              cnt_q   <= CntW'(MUL_STAGES - 1);
            end else if (div_skip) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              early_q <= 1'b1;
            end else begin
              state_q <= StDiv;
            end
          end else if (mt_write) begin
            if (op == OpMthi) hi_q <= bus.src1_i;
            else              lo_q <= bus.src1_i;
          end
        end
        StMul: begin
          if (cnt_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDiv: begin
          if (div_done) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          hi_q    <= hi_res;
          lo_q    <= lo_res;
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
